// File: rtl/mem_pkg.sv
// mem_pkg: memory-stage FSM state enum, default access timeout and 32-bit word type
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_t;
  localparam int TIMEOUT_DEF = 16;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_stage_timeout_cnt.sv
// mem_timeout_cnt: saturating wait counter (clk, reset_n, clr, en in; hit out, high on the enabled cycle that brings the count to MAX)
module mem_timeout_cnt #(
  parameter int MAX = 16,
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] cnt;
  assign hit = en & (cnt == W'(MAX - 1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: E->M register and dmem req/ready FSM with timeout; ports clk, reset_n, E-stage inputs, *M outputs to W, dmem_* handshake, StallM, sticky MemErrM; MEM_STALL_CNT_EN adds StallCntM
module mem_stage import mem_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ValidE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [3:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  output logic        StallM,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [3:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] ReadDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0] StallCntM,
`endif
  output logic        MemErrM
);
  mem_state_t state, state_n;
  logic valid_r, pcsrc_r, rw_r, m2r_r, mw_r, memop, cnt_en, hit;
  logic [3:0] rd_r;
  word_t alu_r, wd_r;
  assign memop = valid_r & (m2r_r | mw_r);
  assign dmem_req = memop & (state != ERR);
  assign dmem_we = dmem_req & mw_r;
  assign dmem_addr = alu_r;
  assign dmem_wdata = wd_r;
  assign cnt_en = dmem_req & ~dmem_ready;
  assign StallM = cnt_en | (state == ERR);
  assign RegWriteM = rw_r & valid_r & ~StallM;
  assign PCSrcM = pcsrc_r & valid_r & ~StallM;
  assign MemtoRegM = m2r_r & valid_r & ~StallM;
  assign RdM = rd_r;
  assign ALUResultM = alu_r;
  assign ReadDataM = (dmem_req & dmem_ready) ? dmem_rdata : '0;
  always_comb
    state_n = state == IDLE ? ((memop & ~dmem_ready) ? WAIT : IDLE) :
              state == WAIT ? (dmem_ready ? IDLE : hit ? ERR : WAIT) : IDLE;
  mem_timeout_cnt #(.MAX(TIMEOUT), .W(CNT_W)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .clr(~cnt_en),
    .en(cnt_en),
    .hit(hit)
  );
  // The abandoned access is killed as it leaves ERR so it is not reissued.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      valid_r <= 1'b0;
      pcsrc_r <= 1'b0;
      rw_r <= 1'b0;
      m2r_r <= 1'b0;
      mw_r <= 1'b0;
      rd_r <= '0;
      alu_r <= '0;
      wd_r <= '0;
      MemErrM <= 1'b0;
    end else begin
      state <= state_n;
      MemErrM <= MemErrM | (state_n == ERR);
      if (state == ERR) valid_r <= 1'b0;
      else if (!StallM) begin
        valid_r <= ValidE;
        pcsrc_r <= PCSrcE;
        rw_r <= RegWriteE;
        m2r_r <= MemtoRegE;
        mw_r <= MemWriteE;
        rd_r <= RdE;
        alu_r <= ALUResultE;
        wd_r <= WriteDataE;
      end
    end
`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) StallCntM <= '0;
    else if (StallM) StallCntM <= StallCntM + 1'b1;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand sequences for wait, timeout, async reset and stall counting
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset_n, ValidE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
  logic [3:0] RdE;
  logic [31:0] ALUResultE, WriteDataE;
  logic StallM, PCSrcM, RegWriteM, MemtoRegM;
  logic [3:0] RdM;
  logic [31:0] ALUResultM, ReadDataM;
  logic dmem_req, dmem_we, dmem_ready, MemErrM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] StallCntM;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .RdE(RdE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .StallM(StallM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .RdM(RdM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
`ifdef MEM_STALL_CNT_EN
    .StallCntM(StallCntM),
`endif
    .MemErrM(MemErrM)
  );

  typedef struct {
    logic v, pc, rw, m2r, mw;
    logic [3:0] rd;
    logic [31:0] alu, wd;
    logic rdy;
    logic [31:0] rdata;
  } in_t;

  typedef struct {
    in_t i;
    logic [31:0] e[10];
  } vec_t;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic in_t mk(input logic v, pc, rw, m2r, mw, input logic [3:0] rd,
                             input logic [31:0] alu, wd, input logic rdy, input logic [31:0] rdata);
    in_t x;
    x.v = v; x.pc = pc; x.rw = rw; x.m2r = m2r; x.mw = mw;
    x.rd = rd; x.alu = alu; x.wd = wd; x.rdy = rdy; x.rdata = rdata;
    return x;
  endfunction

  task automatic drive(input in_t x);
    ValidE = x.v; PCSrcE = x.pc; RegWriteE = x.rw; MemtoRegE = x.m2r; MemWriteE = x.mw;
    RdE = x.rd; ALUResultE = x.alu; WriteDataE = x.wd; dmem_ready = x.rdy; dmem_rdata = x.rdata;
  endtask

  task automatic cyc(input in_t x);
    @(posedge clk);
    #1;
    drive(x);
    @(negedge clk);
  endtask

  task automatic access(input int n);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h600, 32'h1, 1'b0, 32'h0));
    for (int k = 0; k < n; k++) cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0));
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h0));
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v[7];
    string nm[10];
    logic [31:0] act[10];
    in_t bub, alu9, ld;
    int n;
    logic wb, err_seen, done;
    nm = '{"stall", "regwrite", "pcsrc", "memtoreg", "req", "we", "rd", "aluresult", "readdata", "addr"};
    bub = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    v[0].i = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, 1'b0, 32'h0);
    v[0].e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1].i = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    v[1].e = '{0, 1, 0, 0, 0, 0, 3, 32'h55, 0, 32'h55};
    v[2].i = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
    v[2].e = '{0, 1, 0, 1, 1, 0, 5, 32'h100, 32'hDEADBEEF, 32'h100};
    v[3].i = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h200, 32'h0, 1'b1, 32'h1234);
    v[3].e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[4].i = bub;
    v[4].e = '{0, 1, 1, 0, 0, 0, 7, 32'h200, 0, 32'h200};
    v[5].i = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h40, 32'hCAFE, 1'b1, 32'h0);
    v[5].e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[6].i = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h99);
    v[6].e = '{0, 0, 0, 0, 1, 1, 2, 32'h40, 32'h99, 32'h40};

    reset_n = 1'b1;
    drive(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             $urandom, $urandom, 1'b1, $urandom));
    #1 reset_n = 1'b0;
    #1;
    chk("reset_stall", 32'(StallM), 32'h0);
    chk("reset_regwrite", 32'(RegWriteM), 32'h0);
    chk("reset_req", 32'(dmem_req), 32'h0);
    chk("reset_readdata", ReadDataM, 32'h0);
    chk("reset_alu", ALUResultM, 32'h0);
    chk("reset_err", 32'(MemErrM), 32'h0);
    repeat (2) @(negedge clk);
    drive(bub);
    reset_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      cyc(v[t].i);
      act = '{32'(StallM), 32'(RegWriteM), 32'(PCSrcM), 32'(MemtoRegM), 32'(dmem_req),
              32'(dmem_we), 32'(RdM), ALUResultM, ReadDataM, dmem_addr};
      for (int f = 0; f < 10; f++) chk($sformatf("vec%0d_%s", t, nm[f]), act[f], v[t].e[f]);
    end

    alu9 = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h77, 32'h0, 1'b0, 32'h0);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h300, 32'hA5A5, 1'b0, 32'h0));
    for (int k = 0; k < 3; k++) begin
      cyc(alu9);
      chk($sformatf("wait%0d_stall", k), 32'(StallM), 32'h1);
      chk($sformatf("wait%0d_req", k), 32'(dmem_req), 32'h1);
      chk($sformatf("wait%0d_we", k), 32'(dmem_we), 32'h1);
      chk($sformatf("wait%0d_addr", k), dmem_addr, 32'h300);
      chk($sformatf("wait%0d_wdata", k), dmem_wdata, 32'hA5A5);
      chk($sformatf("wait%0d_regwrite", k), 32'(RegWriteM), 32'h0);
    end
    alu9.rdy = 1'b1;
    cyc(alu9);
    chk("wait_done_stall", 32'(StallM), 32'h0);
    chk("wait_done_req", 32'(dmem_req), 32'h1);
    cyc(bub);
    chk("next_rd", 32'(RdM), 32'h9);
    chk("next_alu", ALUResultM, 32'h77);
    chk("next_regwrite", 32'(RegWriteM), 32'h1);
    chk("next_req", 32'(dmem_req), 32'h0);

    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 32'h400, 32'h0, 1'b0, 32'h0));
    n = 0; wb = 1'b0; err_seen = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc(bub);
      if (StallM) begin
        n++;
        if (RegWriteM || MemtoRegM || PCSrcM) wb = 1'b1;
        if (!dmem_req) err_seen = MemErrM;
      end else if (n > 0) done = 1'b1;
    end
    chk("timeout_stall_cycles", 32'(n), 32'd17);
    chk("timeout_writeback", 32'(wb), 32'h0);
    chk("timeout_err_in_err_cycle", 32'(err_seen), 32'h1);
    chk("timeout_err_after", 32'(MemErrM), 32'h1);
    cyc(bub);
    chk("timeout_err_sticky", 32'(MemErrM), 32'h1);
    chk("timeout_idle_stall", 32'(StallM), 32'h0);
    chk("timeout_idle_req", 32'(dmem_req), 32'h0);

    ld = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h500, 32'h0, 1'b0, 32'h0);
    cyc(ld);
    cyc(bub);
    cyc(bub);
    chk("rst_pre_req", 32'(dmem_req), 32'h1);
    chk("rst_pre_stall", 32'(StallM), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'h0);
    chk("rst_mid_stall", 32'(StallM), 32'h0);
    chk("rst_mid_err", 32'(MemErrM), 32'h0);
    chk("rst_mid_regwrite", 32'(RegWriteM), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(bub);
    chk("rst_post_req", 32'(dmem_req), 32'h0);
    chk("rst_post_stall", 32'(StallM), 32'h0);

`ifdef MEM_STALL_CNT_EN
    chk("stallcnt_zero", StallCntM, 32'h0);
    access(3);
    access(5);
    chk("stallcnt_total", StallCntM, 32'd8);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
